// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the scan-chain initiator
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } scan_state_t;

    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    localparam int DEFAULT_CHAIN_LEN = 32;

endpackage

// File: rtl/scan_ctrl_if.sv
// rtl/scan_ctrl_if.sv - host command/response handshake bundle for scan_ctrl
interface scan_ctrl_if #(
    parameter int CHAIN_LEN = scan_pkg::DEFAULT_CHAIN_LEN
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_load;
    logic [CHAIN_LEN-1:0] cmd_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_rdata;

    modport master (
        output cmd_valid,
        output cmd_load,
        output cmd_wdata,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  cmd_valid,
        input  cmd_load,
        input  cmd_wdata,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/scan_shift_unit.sv
// rtl/scan_shift_unit.sv - transmit/receive shift registers and shift counter
module scan_shift_unit #(
    parameter int CHAIN_LEN = scan_pkg::DEFAULT_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] wdata,
    input  logic                 shift,
    input  logic                 sout,
    output logic                 tx_msb,
    output logic [CHAIN_LEN-1:0] rx_data,
    output logic                 done
);

    logic [CHAIN_LEN-1:0] tx_sr;
    logic [CHAIN_LEN-1:0] rx_sr;
    logic [CNT_W-1:0]     cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sr <= '0;
            rx_sr <= '0;
            cnt   <= '0;
        end else if (start) begin
            tx_sr <= wdata;
            rx_sr <= '0;
            cnt   <= '0;
        end else if (shift) begin
            tx_sr <= tx_sr << 1;
            rx_sr <= {rx_sr[CHAIN_LEN-2:0], sout};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Flags the shift that completes the word so the FSM leaves SHIFT on that same edge.
    assign done    = shift && (cnt == CNT_W'(CHAIN_LEN - 1));
    assign tx_msb  = tx_sr[CHAIN_LEN-1];
    assign rx_data = rx_sr;

endmodule

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - scan-chain initiator: parallel load/read commands to a serial scan port
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
    input  logic        clk,
    input  logic        reset,
    scan_ctrl_if.slave  bus,
    input  logic        pause,
    output logic        scan_sen,
    output logic        scan_ce,
    output logic        scan_sin,
    input  logic        scan_sout,
    output logic        busy
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    scan_state_t state, state_nxt;
    logic        mode;
    logic        start;
    logic        shift;
    logic        tx_msb;
    logic        done;
    logic        cmd_ready;
    logic        rsp_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mode  <= MODE_READ;
        end else begin
            state <= state_nxt;
            if (start) mode <= bus.cmd_load;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        scan_sen  = 1'b0;
        scan_ce   = 1'b0;
        scan_sin  = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                scan_sen = 1'b1;
                scan_ce  = !pause;
                // A read feeds sout straight back so the chain is restored after a full pass.
                scan_sin = (mode == MODE_LOAD) ? tx_msb : scan_sout;
                if (done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign shift         = scan_ce;
    assign busy          = (state != IDLE);
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;

    scan_shift_unit #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .wdata   (bus.cmd_wdata),
        .shift   (shift),
        .sout    (scan_sout),
        .tx_msb  (tx_msb),
        .rx_data (bus.rsp_rdata),
        .done    (done)
    );

endmodule
